// File: rtl/order_tx_fifo_if.sv
// Avalon-MM register window and valid/ready order stream for order_tx_fifo.
interface order_tx_fifo_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output chipselect, address, read, write, writedata, out_ready,
        input  readdata, out_data, out_valid
    );

    modport slave (
        input  chipselect, address, read, write, writedata, out_ready,
        output readdata, out_data, out_valid
    );
endinterface

// File: rtl/order_tx_fifo.sv
// Show-ahead order FIFO behind an Avalon-MM slave, drained onto a valid/ready stream.
// Optional delivered-word counter SENT is built when ORDER_TX_FIFO_STATS_EN is defined.
module order_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset,
    order_tx_fifo_if.slave bus,
    output logic           irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_next;
    logic [DEPTH_LOG2:0]   thresh;
    logic [DEPTH_LOG2:0]   thresh_next;
    logic                  drain_en;
    logic                  drain_en_next;
    logic                  irq_en;
    logic                  irq_en_next;
    logic                  ovf;
    logic                  ovf_next;
    logic                  irq_next;

    logic wr_sel;
    logic rd_sel;
    logic push_req;
    logic push;
    logic pop;
    logic flush;
    logic empty;
    logic full;
    logic [31:0] rd_value;
    logic [31:0] sent;

    always_comb begin
        wr_sel   = bus.chipselect & bus.write;
        rd_sel   = bus.chipselect & bus.read;
        empty    = (level == '0);
        full     = (level == FULL_LEVEL);
        push_req = wr_sel && (bus.address == 3'd0);
        push     = push_req && !full;
        flush    = wr_sel && (bus.address == 3'd2) && bus.writedata[2];
        pop      = bus.out_valid & bus.out_ready;
    end

    assign bus.out_valid = drain_en & !empty;
    assign bus.out_data  = mem[rd_ptr];

    always_comb begin
        level_next    = level;
        drain_en_next = drain_en;
        irq_en_next   = irq_en;
        thresh_next   = thresh;
        ovf_next      = ovf;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
        if (wr_sel && (bus.address == 3'd2)) begin
            drain_en_next = bus.writedata[0];
            irq_en_next   = bus.writedata[1];
        end
        if (wr_sel && (bus.address == 3'd3)) begin
            thresh_next = bus.writedata[DEPTH_LOG2:0];
        end
        if (push_req && full) begin
            ovf_next = 1'b1;
        end else if (wr_sel && (bus.address == 3'd1) && bus.writedata[18]) begin
            ovf_next = 1'b0;
        end
        // irq is judged on the post-update state so it tracks the level it reports
        irq_next = irq_en_next & ((level_next <= thresh_next) | ovf_next);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drain_en <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= '0;
            ovf      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_next;
            drain_en <= drain_en_next;
            irq_en   <= irq_en_next;
            thresh   <= thresh_next;
            ovf      <= ovf_next;
            irq      <= irq_next;
        end
    end

`ifdef ORDER_TX_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sent <= '0;
        end else if (wr_sel && (bus.address == 3'd4)) begin
            sent <= {31'b0, pop};
        end else if (pop) begin
            sent <= sent + 32'd1;
        end
    end
`else
    assign sent = '0;
`endif

    always_comb begin
        rd_value = '0;
        case (bus.address)
            3'd1: begin
                rd_value[DEPTH_LOG2:0] = level;
                rd_value[16]           = empty;
                rd_value[17]           = full;
                rd_value[18]           = ovf;
            end
            3'd2: begin
                rd_value[0] = drain_en;
                rd_value[1] = irq_en;
            end
            3'd3:    rd_value[DEPTH_LOG2:0] = thresh;
            3'd4:    rd_value = sent;
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_sel) begin
            bus.readdata <= rd_value;
        end
    end
endmodule

// File: tb/tb_order_tx_fifo.sv
// Scoreboard bench for order_tx_fifo: stream and register-read monitors check queued expectations.
module tb_order_tx_fifo;
`ifdef ORDER_TX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int checks = 0;
    int failures = 0;

    order_tx_fifo_if bus ();

    order_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] sb_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        rd_accept = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    always @(posedge clk) rd_accept <= !reset && bus.chipselect && bus.read;

    // readdata monitor: one comparison per accepted read, a cycle after the strobe
    always @(negedge clk) begin
        if (rd_accept) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", bus.readdata, 32'hDEAD_BEEF);
            end else begin
                check(rd_name_q.pop_front(), bus.readdata, rd_exp_q.pop_front());
            end
        end
    end

    // stream monitor: every transfer must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stream_unexpected actual=%08h expected=none", bus.out_data);
            end else begin
                check("stream_data", bus.out_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lvl;
        logic xfer;

        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        rd(3'd1, 32'h0001_0000, "reset_status");

        // three words held back, then drained back to back
        wr(3'd0, 32'h11); sb_q.push_back(32'h11);
        wr(3'd0, 32'h22); sb_q.push_back(32'h22);
        wr(3'd0, 32'h33); sb_q.push_back(32'h33);
        rd(3'd1, 32'h0000_0003, "status_level3");
        bus.out_ready = 1'b1;
        wr(3'd2, 32'h1);
        repeat (5) tick();
        check("drain3_out_valid", {31'b0, bus.out_valid}, 32'd0);
        rd(3'd2, 32'h1, "ctrl_drain");
        rd(3'd4, STATS ? 32'd3 : 32'd0, "sent_3");

        // overflow: 17 pushes into a 16-deep FIFO
        wr(3'd2, 32'h0);
        for (int i = 0; i < 17; i++) begin
            wr(3'd0, 32'h100 + i);
            if (i < 16) sb_q.push_back(32'h100 + i);
        end
        rd(3'd1, 32'h0006_0010, "status_full_ovf");
        wr(3'd1, 32'h0004_0000);
        rd(3'd1, 32'h0002_0010, "status_ovf_clr");
        wr(3'd2, 32'h1);
        repeat (20) tick();
        check("ovf_drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("ovf_drain_sb_empty", sb_q.size(), 32'd0);
        rd(3'd4, STATS ? 32'd19 : 32'd0, "sent_19");

        // low-water interrupt with a stalling consumer
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h2);
        for (int i = 0; i < 4; i++) begin
            wr(3'd0, 32'h200 + i);
            sb_q.push_back(32'h200 + i);
        end
        bus.out_ready = 1'b0;
        wr(3'd2, 32'h2);
        check("irq_level4", {31'b0, irq}, 32'd0);
        wr(3'd2, 32'h3);
        check("irq_drain_start", {31'b0, irq}, 32'd0);
        lvl = 4;
        for (int i = 0; i < 10; i++) begin
            bus.out_ready = (i % 2 == 1);
            #1;
            xfer = bus.out_valid && bus.out_ready;
            tick();
            if (xfer) lvl--;
            check("irq_lowwater", {31'b0, irq}, (lvl <= 2) ? 32'd1 : 32'd0);
            if (lvl > 0) check("stall_head", bus.out_data, 32'h200 + 32'(4 - lvl));
        end
        check("irq_drained_level", lvl, 32'd0);
        wr(3'd2, 32'h1);
        check("irq_disabled", {31'b0, irq}, 32'd0);

        // sustained push/pop through pointer wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr(3'd0, 32'h300 + i);
            sb_q.push_back(32'h300 + i);
        end
        repeat (2) tick();
        rd(3'd1, 32'h0001_0000, "stream_status_empty");
        rd(3'd4, STATS ? 32'd63 : 32'd0, "sent_63");

        // flush with five words queued
        wr(3'd2, 32'h0);
        for (int i = 0; i < 5; i++) wr(3'd0, 32'h500 + i);
        rd(3'd1, 32'h0000_0005, "status_level5");
        wr(3'd2, 32'h5);
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        rd(3'd1, 32'h0001_0000, "flush_status");
        rd(3'd2, 32'h1, "ctrl_no_flush_bit");
        wr(3'd0, 32'h400);
        sb_q.push_back(32'h400);
        repeat (3) tick();
        rd(3'd4, STATS ? 32'd64 : 32'd0, "sent_64");

        // remaining register map corners
        wr(3'd4, 32'h123);
        rd(3'd4, 32'd0, "sent_cleared");
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h1F, "thresh_mask");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd5, 32'd0, "addr5_zero");
        rd(3'd0, 32'd0, "txdata_read_zero");
        rd(3'd2, 32'h1, "ctrl_after_addr6");

        repeat (3) tick();
        check("sb_final_empty", sb_q.size(), 32'd0);
        check("rd_final_empty", rd_exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/order_tx_fifo.md
# order_tx_fifo

Avalon-MM slave peripheral on the lightweight HPS-to-FPGA bridge of `soc_system`, directly downstream of the HPS. Software pushes 32-bit order words through a register window. The block buffers them in a show-ahead FIFO and drains them onto a valid/ready stream toward the fabric order logic. It also provides level, overflow, low-water interrupt and delivered-word statistics.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `clk` input 1: sole clock, same domain as the bridge master.
- `reset` input 1: synchronous, active-high. The clock is one domain and the reset polarity and synchronicity are fixed.
- `chipselect` input 1: Avalon slave select.
- `address` input 3: word address.
- `read` input 1: read strobe, qualified by chipselect.
- `write` input 1: write strobe, qualified by chipselect.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data, read latency 1.
- `irq` output 1: level interrupt to the HPS, registered.
- `out_data` output 32: FIFO head word.
- `out_valid` output 1: head is valid and the drain is enabled.
- `out_ready` input 1: downstream accepts.

## Operation
- Register map (word address):
  - 0 TX_DATA (W): push `writedata`. If the FIFO is full, the word is dropped and OVF is set. Reads return 0.
  - 1 STATUS (R): [DEPTH_LOG2:0] level, bit16 empty, bit17 full, bit18 OVF sticky. A write with bit18=1 clears OVF; other bits are ignored.
  - 2 CTRL (R/W): bit0 DRAIN_EN, bit1 IRQ_EN, bit2 FLUSH. FLUSH is write-only, self-clearing and reads 0.
  - 3 THRESH (R/W): [DEPTH_LOG2:0] low-water mark. Upper bits are ignored on write and read as 0.
  - 4 SENT (R): delivered-word count. Any write clears it.
  - Addresses 5-7: reads return 0, writes are ignored.
- Storage:
  - Register array with rd/wr pointers of DEPTH_LOG2 bits that wrap modulo depth.
  - `level` is a separate DEPTH_LOG2+1 bit counter.
- Stream output:
  - `out_valid = DRAIN_EN & !empty`.
  - `out_data = mem[rd_ptr]`.
  - A transfer occurs when `out_valid & out_ready`; it then advances rd_ptr and decrements level.
  - `out_data` holds stable while `out_valid & !out_ready`.
- Full/empty decisions use the level at the start of the cycle:
  - A push while full is dropped even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves level unchanged.
- Flush clears the pointers and level next cycle. A stream transfer in the flush cycle is still counted in SENT. OVF is not affected.
- `irq` next cycle = `IRQ_EN & ((level <= THRESH) | OVF)`, evaluated on the updated level.
- Clearing DRAIN_EN mid-stream drops `out_valid` immediately (combinational). The head word is retained.

## Timing
- Reset values: `readdata`=0, `irq`=0, `out_valid`=0, level=0, OVF=0, CTRL=0, THRESH=0, SENT=0, pointers=0.
- Push in cycle N: level and `out_valid` (if DRAIN_EN) update at N+1. The word appears on `out_data` at N+1 when the FIFO was empty.
- Read accepted in cycle N: `readdata` valid at N+1. Between reads it holds the last value.
- A STATUS read in cycle N returns the state at the start of cycle N.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-transfer: all state clears. The FIFO contents are discarded (memory is not cleared, but it is unreachable).

## Configuration
- `ORDER_TX_FIFO_STATS_EN`:
  - Defined: the 32-bit SENT counter is built. It increments on every stream transfer, wraps 0xFFFFFFFF→0, and is cleared by a write. A simultaneous clear and transfer yields 1.
  - Undefined: no counter logic is built. SENT reads 0 and writes are ignored.

## Test plan
- Reset, then read STATUS → 0x0001_0000 (empty, level 0). `irq`=0 and `out_valid`=0.
- DRAIN_EN=0; push 0x11,0x22,0x33 → STATUS level=3. Set DRAIN_EN with `out_ready`=1 → `out_data` 0x11,0x22,0x33 on three consecutive cycles, then `out_valid`=0. SENT=3 (with STATS_EN).
- DRAIN_EN=0; push 17 words into the depth-16 FIFO → STATUS full=1, OVF=1, level=16. The 17th word is never output. Write STATUS 0x0004_0000 → OVF=0.
- THRESH=2, IRQ_EN=1, 4 words queued, drain with `out_ready` toggling every other cycle → `irq` rises the cycle after level reaches 2. `out_data` is stable during stalls.
- DRAIN_EN=1, `out_ready`=1, push every cycle for 40 cycles → pointers wrap, level stays ≤1, and the output order equals the input order.
- Write CTRL FLUSH with 5 words queued → next cycle level=0 and `out_valid`=0. CTRL reads back without bit2.
